// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: EXE->MEM register, load extraction, WB handshake and ID forwarding.
// Optional lwl/lwr merging is enabled by defining MS_UNALIGNED_LOAD_EN.
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ws_allowin,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [118:0] es_to_ms_bus,
    input  logic [31:0]  data_sram_rdata,
    output logic         ms_to_ws_valid,
    output logic [69:0]  ms_to_ws_bus,
    output logic [37:0]  ms_fwd_bus
);
    localparam int ES_TO_MS_BUS_WD = 119;
    localparam int MS_TO_WS_BUS_WD = 70;

    logic                       ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] bus_r;
    logic [31:0]                rdata_hold;
    logic                       hold_valid;

    logic [31:0] rt_value;
    logic [15:0] ld_ext;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign {rt_value, ld_ext, res_from_mem, gr_we, dest, alu_result, pc} = bus_r;

    logic unused_fields;
`ifdef MS_UNALIGNED_LOAD_EN
    assign unused_fields = &{1'b0, ld_ext[15:6]};
`else
    assign unused_fields = &{1'b0, rt_value, ld_ext[15:4]};
`endif

    logic ms_ready_go;
    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
        if (es_to_ms_valid && ms_allowin) begin
            bus_r <= es_to_ms_bus;
        end
    end

    // The SRAM only presents read data for one cycle, so a stalled load keeps its own copy.
    always_ff @(posedge clk) begin
        if (reset || ms_allowin) begin
            hold_valid <= 1'b0;
        end else if (ms_valid && res_from_mem && !hold_valid && !ws_allowin) begin
            hold_valid <= 1'b1;
            rdata_hold <= data_sram_rdata;
        end
    end

    logic [31:0] mem_word;
    logic [7:0]  byte_data;
    logic [15:0] half_data;
    logic [31:0] load_result;
    logic [31:0] final_result;

    always_comb begin
        mem_word    = hold_valid ? rdata_hold : data_sram_rdata;
        byte_data   = mem_word[{alu_result[1:0], 3'b000} +: 8];
        half_data   = alu_result[1] ? mem_word[31:16] : mem_word[15:0];
        load_result = mem_word;
        if (ld_ext[0]) begin
            load_result = {{24{byte_data[7]}}, byte_data};
        end else if (ld_ext[1]) begin
            load_result = {24'b0, byte_data};
        end else if (ld_ext[2]) begin
            load_result = {{16{half_data[15]}}, half_data};
        end else if (ld_ext[3]) begin
            load_result = {16'b0, half_data};
`ifdef MS_UNALIGNED_LOAD_EN
        end else if (ld_ext[4]) begin
            case (alu_result[1:0])
                2'd0:    load_result = {mem_word[7:0],  rt_value[23:0]};
                2'd1:    load_result = {mem_word[15:0], rt_value[15:0]};
                2'd2:    load_result = {mem_word[23:0], rt_value[7:0]};
                default: load_result = mem_word;
            endcase
        end else if (ld_ext[5]) begin
            case (alu_result[1:0])
                2'd0:    load_result = mem_word;
                2'd1:    load_result = {rt_value[31:24], mem_word[31:8]};
                2'd2:    load_result = {rt_value[31:16], mem_word[31:16]};
                default: load_result = {rt_value[31:8],  mem_word[31:24]};
            endcase
`endif
        end
        final_result = res_from_mem ? load_result : alu_result;
    end

    logic [MS_TO_WS_BUS_WD-1:0] ws_bus_raw;
    assign ws_bus_raw   = {gr_we, dest, final_result, pc};
    assign ms_to_ws_bus = ms_valid ? ws_bus_raw : '0;
    assign ms_fwd_bus   = ms_valid ? {gr_we, dest, final_result} : '0;
endmodule
